// File: rtl/sal_resp_merger_if.sv
// Bundle of the bank-side response buses and the merged AXI R/B channels.
// The merger connects through the slave modport; the surrounding fabric or a
// testbench drives the opposite side through the master modport.

`ifndef DRAM_BK_CNT
`define DRAM_BK_CNT 4
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface sal_resp_merger_if #(
  parameter int BK_CNT = `DRAM_BK_CNT,
  parameter int ID_W   = `AXI_ID_WIDTH,
  parameter int DATA_W = `AXI_DATA_WIDTH
);
  logic [BK_CNT-1:0]             bk_rvalid;
  logic [BK_CNT-1:0][ID_W-1:0]   bk_rid;
  logic [BK_CNT-1:0][DATA_W-1:0] bk_rdata;
  logic [BK_CNT-1:0]             bk_rlast;
  logic [BK_CNT-1:0]             bk_rready;
  logic [BK_CNT-1:0]             bk_bvalid;
  logic [BK_CNT-1:0][ID_W-1:0]   bk_bid;
  logic [BK_CNT-1:0]             bk_bready;

  logic              rvalid;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rready;

  logic              bvalid;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bready;

  modport slave (
    input  bk_rvalid, bk_rid, bk_rdata, bk_rlast, bk_bvalid, bk_bid,
    output bk_rready, bk_bready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready,
    output bvalid, bid, bresp,
    input  bready
  );

  modport master (
    output bk_rvalid, bk_rid, bk_rdata, bk_rlast, bk_bvalid, bk_bid,
    input  bk_rready, bk_bready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready,
    input  bvalid, bid, bresp,
    output bready
  );
endinterface

// File: rtl/sal_resp_merger.sv
// Merges per-bank read beats and write completions onto one AXI R and one
// AXI B channel. Read bursts are never interleaved: once a bank wins with a
// non-last beat it keeps the R channel until its last beat. Both outputs are
// single register stages, and the two paths arbitrate independently.

`ifndef DRAM_BK_CNT
`define DRAM_BK_CNT 4
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module sal_resp_merger #(
  parameter int BK_CNT = `DRAM_BK_CNT,
  parameter int ID_W   = `AXI_ID_WIDTH,
  parameter int DATA_W = `AXI_DATA_WIDTH
) (
  input logic              clk,
  input logic              rst,
  sal_resp_merger_if.slave bus
);

  localparam int PTR_W = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_e;

  // Bank index plus one, wrapping at the last bank (BK_CNT need not be 2^n).
  function automatic ptr_t inc_mod(input ptr_t p);
    if (int'(p) == BK_CNT - 1) return '0;
    return p + ptr_t'(1);
  endfunction

  // First requesting bank at or after ptr, walking round-robin.
  function automatic ptr_t rr_pick(input logic [BK_CNT-1:0] req, input ptr_t ptr,
                                   output logic found);
    ptr_t idx;
    ptr_t pick;
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < BK_CNT; i++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
      idx = inc_mod(idx);
    end
    return pick;
  endfunction

  r_state_e          r_state_q, r_state_d;
  ptr_t              lk_q, lk_d;
  ptr_t              r_ptr_q, r_ptr_d;
  ptr_t              b_ptr_q, b_ptr_d;
  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;

  logic              r_free, r_found, r_sel_valid;
  ptr_t              r_pick, r_sel;
  logic              b_free, b_found;
  ptr_t              b_pick;
  logic [BK_CNT-1:0] bk_rready_c, bk_bready_c;

  // R path: pick the bank (round-robin in IDLE, the locked bank in BURST),
  // accept one beat when the output register is free, and track burst lock.
  always_comb begin
    r_free      = !rvalid_q || bus.rready;
    r_pick      = rr_pick(bus.bk_rvalid, r_ptr_q, r_found);
    r_state_d   = r_state_q;
    lk_d        = lk_q;
    r_ptr_d     = r_ptr_q;
    rvalid_d    = r_free ? 1'b0 : rvalid_q;
    rid_d       = rid_q;
    rdata_d     = rdata_q;
    rlast_d     = rlast_q;
    bk_rready_c = '0;
    if (r_state_q == R_BURST) begin
      r_sel       = lk_q;
      r_sel_valid = bus.bk_rvalid[lk_q];
    end else begin
      r_sel       = r_pick;
      r_sel_valid = r_found;
    end
    if (!rst && r_free && r_sel_valid) begin
      bk_rready_c[r_sel] = 1'b1;
      rvalid_d           = 1'b1;
      rid_d              = bus.bk_rid[r_sel];
      rdata_d            = bus.bk_rdata[r_sel];
      rlast_d            = bus.bk_rlast[r_sel];
      if (r_state_q == R_IDLE) begin
        if (bus.bk_rlast[r_sel]) begin
          r_ptr_d = inc_mod(r_sel);
        end else begin
          r_state_d = R_BURST;
          lk_d      = r_sel;
        end
      end else if (bus.bk_rlast[r_sel]) begin
        r_state_d = R_IDLE;
        r_ptr_d   = inc_mod(lk_q);
      end
    end
  end

  // B path: single-beat round-robin arbitration into its own output register.
  always_comb begin
    b_free      = !bvalid_q || bus.bready;
    b_pick      = rr_pick(bus.bk_bvalid, b_ptr_q, b_found);
    b_ptr_d     = b_ptr_q;
    bvalid_d    = b_free ? 1'b0 : bvalid_q;
    bid_d       = bid_q;
    bk_bready_c = '0;
    if (!rst && b_free && b_found) begin
      bk_bready_c[b_pick] = 1'b1;
      bvalid_d            = 1'b1;
      bid_d               = bus.bk_bid[b_pick];
      b_ptr_d             = inc_mod(b_pick);
    end
  end

  // Control state: valids, FSM, lock and arbitration pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      lk_q      <= '0;
      r_ptr_q   <= '0;
      b_ptr_q   <= '0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      lk_q      <= lk_d;
      r_ptr_q   <= r_ptr_d;
      b_ptr_q   <= b_ptr_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Payload registers carry no reset; they are only meaningful under valid.
  always_ff @(posedge clk) begin
    rid_q   <= rid_d;
    rdata_q <= rdata_d;
    rlast_q <= rlast_d;
    bid_q   <= bid_d;
  end

  assign bus.bk_rready = bk_rready_c;
  assign bus.bk_bready = bk_bready_c;
  assign bus.rvalid    = rvalid_q & ~rst;
  assign bus.rid       = rid_q;
  assign bus.rdata     = rdata_q;
  assign bus.rlast     = rlast_q;
  assign bus.rresp     = 2'b00;
  assign bus.bvalid    = bvalid_q & ~rst;
  assign bus.bid       = bid_q;
  assign bus.bresp     = 2'b00;

endmodule

// File: tb/tb_sal_resp_merger.sv
// Directed bench for sal_resp_merger: per-bank beat queues play the banks,
// every handshake on R/B is logged, and scenarios check the logs.

module tb_sal_resp_merger;

  localparam int BK = 4;
  localparam int IW = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk;
  logic rst;
  logic rready_tb;
  logic bready_tb;
  logic [BK-1:0] r_en;

  beat_t         rq[BK][$];
  logic [IW-1:0] bq[BK][$];

  beat_t         r_log[$];
  int            r_log_cyc[$];
  logic [IW-1:0] b_log_id[$];
  int            b_log_cyc[$];
  int            acc_cyc[$];
  int            acc_bank[$];

  logic          s_rvalid, s_rlast, s_bvalid;
  logic [IW-1:0] s_rid, s_bid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp, s_bresp;
  logic [BK-1:0] s_bk_rready, s_bk_bready;

  int cyc;
  int tests;
  int fails;

  sal_resp_merger_if #(.BK_CNT(BK), .ID_W(IW), .DATA_W(DW)) bus ();

  sal_resp_merger #(.BK_CNT(BK), .ID_W(IW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so a wedged run still ends with a reported failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic beat_t mk(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic l);
    beat_t x;
    x.id   = id;
    x.data = d;
    x.last = l;
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int b = 0; b < BK; b++) begin
      if (rq[b].size() > 0 && r_en[b]) begin
        bus.bk_rvalid[b] = 1'b1;
        bus.bk_rid[b]    = rq[b][0].id;
        bus.bk_rdata[b]  = rq[b][0].data;
        bus.bk_rlast[b]  = rq[b][0].last;
      end else begin
        bus.bk_rvalid[b] = 1'b0;
        bus.bk_rid[b]    = '0;
        bus.bk_rdata[b]  = '0;
        bus.bk_rlast[b]  = 1'b0;
      end
      if (bq[b].size() > 0) begin
        bus.bk_bvalid[b] = 1'b1;
        bus.bk_bid[b]    = bq[b][0];
      end else begin
        bus.bk_bvalid[b] = 1'b0;
        bus.bk_bid[b]    = '0;
      end
    end
    bus.rready = rready_tb;
    bus.bready = bready_tb;
  endtask

  task automatic tick();
    logic [BK-1:0] racc;
    logic [BK-1:0] bacc;
    applyStimulus();
    @(negedge clk);
    s_rvalid    = bus.rvalid;
    s_rid       = bus.rid;
    s_rdata     = bus.rdata;
    s_rlast     = bus.rlast;
    s_rresp     = bus.rresp;
    s_bvalid    = bus.bvalid;
    s_bid       = bus.bid;
    s_bresp     = bus.bresp;
    s_bk_rready = bus.bk_rready;
    s_bk_bready = bus.bk_bready;
    racc = bus.bk_rvalid & bus.bk_rready;
    bacc = bus.bk_bvalid & bus.bk_bready;
    if (bus.rvalid && bus.rready) begin
      r_log.push_back(mk(bus.rid, bus.rdata, bus.rlast));
      r_log_cyc.push_back(cyc);
    end
    if (bus.bvalid && bus.bready) begin
      b_log_id.push_back(bus.bid);
      b_log_cyc.push_back(cyc);
    end
    for (int b = 0; b < BK; b++) begin
      if (racc[b]) begin
        acc_cyc.push_back(cyc);
        acc_bank.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int b = 0; b < BK; b++) begin
      if (racc[b]) void'(rq[b].pop_front());
      if (bacc[b]) void'(bq[b].pop_front());
    end
    applyStimulus();
  endtask

  function automatic logic pending();
    logic p;
    p = bus.rvalid || bus.bvalid;
    for (int b = 0; b < BK; b++) begin
      if ((rq[b].size() > 0 && r_en[b]) || bq[b].size() > 0) p = 1'b1;
    end
    return p;
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (pending() && n < 60) begin
      tick();
      n++;
    end
    checkOutput({tag, "_drain_done"}, 32'(n < 60), 32'd1);
  endtask

  task automatic clearLogs();
    r_log.delete();
    r_log_cyc.delete();
    b_log_id.delete();
    b_log_cyc.delete();
    acc_cyc.delete();
    acc_bank.delete();
  endtask

  task automatic waitAccepts(input string tag, input int cnt);
    int n;
    n = 0;
    while (acc_cyc.size() < cnt && n < 30) begin
      tick();
      n++;
    end
    checkOutput({tag, "_accept_wait"}, 32'(acc_cyc.size()), 32'(cnt));
  endtask

  // Directed scenario sequence; arbitration pointers carry over between steps.
  initial begin
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    rst       = 1'b1;
    rready_tb = 1'b1;
    bready_tb = 1'b1;
    r_en      = '1;

    // Reset: offers present but nothing may be granted or presented.
    rq[3].push_back(mk(4'd1, 32'h300, 1'b1));
    bq[0].push_back(4'd2);
    tick();
    tick();
    checkOutput("rst_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("rst_bvalid", 32'(s_bvalid), 32'd0);
    checkOutput("rst_bk_rready", 32'(s_bk_rready), 32'd0);
    checkOutput("rst_bk_bready", 32'(s_bk_bready), 32'd0);
    checkOutput("rst_rresp", 32'(s_rresp), 32'd0);
    checkOutput("rst_bresp", 32'(s_bresp), 32'd0);
    checkOutput("rst_r_ptr", 32'(dut.r_ptr_q), 32'd0);
    rst = 1'b0;
    drain("s0");
    checkOutput("s0_r_count", 32'(r_log.size()), 32'd1);
    checkOutput("s0_r_data", r_log[0].data, 32'h300);
    checkOutput("s0_r_id", 32'(r_log[0].id), 32'd1);
    checkOutput("s0_b_id", 32'(b_log_id[0]), 32'd2);
    checkOutput("s0_r_ptr_wrap", 32'(dut.r_ptr_q), 32'd0);
    checkOutput("s0_b_ptr", 32'(dut.b_ptr_q), 32'd1);

    // Banks 0 and 1 both hold 2-beat bursts: bank 0 completes first, no interleave.
    clearLogs();
    rq[0].push_back(mk(4'd2, 32'h010, 1'b0));
    rq[0].push_back(mk(4'd2, 32'h011, 1'b1));
    rq[1].push_back(mk(4'd3, 32'h110, 1'b0));
    rq[1].push_back(mk(4'd3, 32'h111, 1'b1));
    drain("s1");
    checkOutput("s1_count", 32'(r_log.size()), 32'd4);
    checkOutput("s1_bank0", 32'(acc_bank[0]), 32'd0);
    checkOutput("s1_bank1", 32'(acc_bank[1]), 32'd0);
    checkOutput("s1_bank2", 32'(acc_bank[2]), 32'd1);
    checkOutput("s1_bank3", 32'(acc_bank[3]), 32'd1);
    checkOutput("s1_data1", r_log[1].data, 32'h011);
    checkOutput("s1_data2", r_log[2].data, 32'h110);
    checkOutput("s1_r_ptr", 32'(dut.r_ptr_q), 32'd2);

    // Bank 2 streams a 4-beat burst, rid 5, rready held high.
    clearLogs();
    for (int k = 0; k < 4; k++) rq[2].push_back(mk(4'd5, 32'h200 + 32'(k), k == 3));
    drain("s2");
    checkOutput("s2_count", 32'(r_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("s2_data%0d", k), r_log[k].data, 32'h200 + 32'(k));
      checkOutput($sformatf("s2_id%0d", k), 32'(r_log[k].id), 32'd5);
      checkOutput($sformatf("s2_last%0d", k), 32'(r_log[k].last), 32'(k == 3));
      checkOutput($sformatf("s2_cycle%0d", k), 32'(r_log_cyc[k]), 32'(acc_cyc[0] + 1 + k));
    end
    checkOutput("s2_r_ptr", 32'(dut.r_ptr_q), 32'd3);

    // Pointer at 3: bank 3 single beat goes before bank 0 (wrap).
    clearLogs();
    rq[3].push_back(mk(4'd8, 32'h320, 1'b1));
    rq[0].push_back(mk(4'd8, 32'h020, 1'b1));
    drain("s3");
    checkOutput("s3_first_bank", 32'(acc_bank[0]), 32'd3);
    checkOutput("s3_second_bank", 32'(acc_bank[1]), 32'd0);
    checkOutput("s3_data0", r_log[0].data, 32'h320);
    checkOutput("s3_r_ptr", 32'(dut.r_ptr_q), 32'd1);

    // Backpressure for 3 cycles while beat 2 of a bank 1 burst is on R.
    clearLogs();
    for (int k = 0; k < 4; k++) rq[1].push_back(mk(4'd6, 32'h120 + 32'(k), k == 3));
    waitAccepts("s4", 2);
    rready_tb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("s4_stall_rvalid%0d", k), 32'(s_rvalid), 32'd1);
      checkOutput($sformatf("s4_stall_rdata%0d", k), s_rdata, 32'h121);
      checkOutput($sformatf("s4_stall_rlast%0d", k), 32'(s_rlast), 32'd0);
      checkOutput($sformatf("s4_stall_bk_rready%0d", k), 32'(s_bk_rready), 32'd0);
    end
    rready_tb = 1'b1;
    drain("s4");
    checkOutput("s4_count", 32'(r_log.size()), 32'd4);
    checkOutput("s4_accepts", 32'(acc_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("s4_data%0d", k), r_log[k].data, 32'h120 + 32'(k));

    // Bank 0 pauses mid-burst while bank 2 waits: lock holds, R bubbles.
    clearLogs();
    for (int k = 0; k < 3; k++) rq[0].push_back(mk(4'd10, 32'h030 + 32'(k), k == 2));
    tick();
    r_en[0] = 1'b0;
    rq[2].push_back(mk(4'd11, 32'h230, 1'b1));
    tick();
    checkOutput("s5_gap_bk_rready0", 32'(s_bk_rready), 32'd0);
    tick();
    checkOutput("s5_gap_bk_rready1", 32'(s_bk_rready), 32'd0);
    checkOutput("s5_bubble_rvalid", 32'(s_rvalid), 32'd0);
    r_en[0] = 1'b1;
    drain("s5");
    checkOutput("s5_bank2_order", 32'(acc_bank[2]), 32'd0);
    checkOutput("s5_bank3_order", 32'(acc_bank[3]), 32'd2);
    checkOutput("s5_data3", r_log[3].data, 32'h230);

    // Completions from banks 1 and 3 arrive together during a bank 3 burst.
    clearLogs();
    for (int k = 0; k < 4; k++) rq[3].push_back(mk(4'd4, 32'h340 + 32'(k), k == 3));
    bq[1].push_back(4'd7);
    bq[3].push_back(4'd9);
    drain("s6");
    checkOutput("s6_b_count", 32'(b_log_id.size()), 32'd2);
    checkOutput("s6_bid0", 32'(b_log_id[0]), 32'd7);
    checkOutput("s6_bid1", 32'(b_log_id[1]), 32'd9);
    checkOutput("s6_b_back_to_back", 32'(b_log_cyc[1]), 32'(b_log_cyc[0] + 1));
    checkOutput("s6_r_count", 32'(r_log.size()), 32'd4);
    checkOutput("s6_r_throughput", 32'(r_log_cyc[3]), 32'(r_log_cyc[0] + 3));
    checkOutput("s6_r_ptr", 32'(dut.r_ptr_q), 32'd0);

    // Reset pulse after beat 2 of a bank 0 burst abandons it; bank 1 then wins.
    clearLogs();
    for (int k = 0; k < 4; k++) rq[0].push_back(mk(4'd12, 32'h040 + 32'(k), k == 3));
    waitAccepts("s7", 2);
    rst = 1'b1;
    tick();
    checkOutput("s7_rst_bk_rready", 32'(s_bk_rready), 32'd0);
    checkOutput("s7_rst_rvalid", 32'(s_rvalid), 32'd0);
    rst = 1'b0;
    rq[0].delete();
    tick();
    checkOutput("s7_post_rvalid", 32'(s_rvalid), 32'd0);
    checkOutput("s7_state_idle", 32'(dut.r_state_q), 32'd0);
    checkOutput("s7_r_ptr", 32'(dut.r_ptr_q), 32'd0);
    checkOutput("s7_beats_before_rst", 32'(r_log.size()), 32'd1);
    clearLogs();
    rq[1].push_back(mk(4'd13, 32'h140, 1'b0));
    rq[1].push_back(mk(4'd13, 32'h141, 1'b1));
    drain("s7");
    checkOutput("s7_new_count", 32'(r_log.size()), 32'd2);
    checkOutput("s7_new_bank", 32'(acc_bank[0]), 32'd1);
    checkOutput("s7_new_data0", r_log[0].data, 32'h140);
    checkOutput("s7_new_last1", 32'(r_log[1].last), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
